demux_dispatch_8: RTL

//  Upstream routing stage for the 1x8 demultiplexer path.
//  - Accepts items over a valid/ready input and delivers each to one of 8 output slots.
//  - Each slot is a 1-entry holding register with its own valid/ready handshake.
//  - Destination comes from in_dest (addressed mode) or from an internal rotating pointer (round-robin mode).
//  - Control FSM gates acceptance and supports a drain-and-flush sequence.

---
 rtl/demux_dispatch_8.sv | 100 ++++++++++
 1 files changed

// File: rtl/demux_dispatch_8.sv
// 1-to-8 dispatch stage: valid/ready input routed into eight 1-entry holding slots,
// addressed or round-robin, with a run/idle/flush control FSM.
//
// state | meaning
// IDLE  | no acceptance; slots may still drain
// RUN   | items accepted into free or draining slots
// FLUSH | no acceptance; wait for every slot to empty, then pulse flush_done
module demux_dispatch_8 #(
  parameter int DATA_W = 1,
  parameter int CNT_W  = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic                flush,
  input  logic                mode,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   in_data,
  input  logic [2:0]          in_dest,
  output logic [8*DATA_W-1:0] out_data,
  output logic [7:0]          out_valid,
  input  logic [7:0]          out_ready,
  output logic [2:0]          sel_last,
  output logic [CNT_W-1:0]    items_total,
  output logic                busy,
  output logic                flush_done
);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t     state, state_nxt;
  logic [2:0] rr_ptr;
  logic [2:0] target;
  logic       accept;
  logic       done_nxt;
  logic [7:0] load;
  logic [7:0] drain;
  logic [7:0] valid_nxt;

  assign target = mode ? rr_ptr : in_dest;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Leaving FLUSH looks at the post-edge slot state so flush_done follows the final drain by one cycle.
  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (flush)       state_nxt = FLUSH;
        else if (enable) state_nxt = RUN;
      end
      RUN: begin
        if (flush)        state_nxt = FLUSH;
        else if (!enable) state_nxt = IDLE;
      end
      FLUSH: begin
        if (valid_nxt == 8'h00) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == RUN) & (!out_valid[target] | out_ready[target]);
    accept    = in_valid & in_ready;
    load      = accept ? (8'h01 << target) : 8'h00;
    drain     = out_valid & out_ready;
    valid_nxt = (out_valid & ~drain) | load;
    busy      = (state != IDLE) | (|out_valid);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid   <= '0;
      out_data    <= '0;
      sel_last    <= '0;
      items_total <= '0;
      rr_ptr      <= '0;
      flush_done  <= 1'b0;
    end else begin
      out_valid  <= valid_nxt;
      flush_done <= done_nxt;
      if (accept) begin
        out_data[target*DATA_W +: DATA_W] <= in_data;
        sel_last <= target;
        if (items_total != {CNT_W{1'b1}}) items_total <= items_total + CNT_W'(1);
        if (mode) rr_ptr <= rr_ptr + 3'd1;
      end
    end
  end

endmodule
